// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ==================================================================
// stopwatch_ctrl_if - divider levels, raw buttons and display drive
// of stopwatch_ctrl; btn_lap only with STOPWATCH_LAP_EN.  Rev 1.0
// ==================================================================
interface stopwatch_ctrl_if;
    logic       sec_lvl;
    logic       deb_lvl;
    logic [1:0] scan_sel;
    logic       btn_start;
    logic       btn_clr;
`ifdef STOPWATCH_LAP_EN
    logic       btn_lap;
`endif
    logic [7:0] ssd;
    logic [3:0] ssd_en;
    logic       running;

`ifdef STOPWATCH_LAP_EN
    modport master (
        output sec_lvl, deb_lvl, scan_sel, btn_start, btn_clr, btn_lap,
        input  ssd, ssd_en, running
    );
    modport slave (
        input  sec_lvl, deb_lvl, scan_sel, btn_start, btn_clr, btn_lap,
        output ssd, ssd_en, running
    );
`else
    modport master (
        output sec_lvl, deb_lvl, scan_sel, btn_start, btn_clr,
        input  ssd, ssd_en, running
    );
    modport slave (
        input  sec_lvl, deb_lvl, scan_sel, btn_start, btn_clr,
        output ssd, ssd_en, running
    );
`endif
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ==================================================================
// stopwatch_ctrl - MM:SS stopwatch with debounced start/clr buttons,
// BCD counter and scanned 7-seg drive; STOPWATCH_LAP_EN adds lap
// freeze.  Rev 1.0
// ==================================================================
module stopwatch_ctrl #(
    parameter int DEB_CNT = 3
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    stopwatch_ctrl_if.slave bus
);
    localparam int CNT_W     = 3;
    localparam int BTN_START = 0;
    localparam int BTN_CLR   = 1;
`ifdef STOPWATCH_LAP_EN
    localparam int BTN_LAP   = 2;
    localparam int N_BTN     = 3;
`else
    localparam int N_BTN     = 2;
`endif

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic [N_BTN-1:0] btn_raw;
`ifdef STOPWATCH_LAP_EN
    assign btn_raw = {bus.btn_lap, bus.btn_clr, bus.btn_start};
`else
    assign btn_raw = {bus.btn_clr, bus.btn_start};
`endif

    logic [1:0]       sec_sync;
    logic [1:0]       deb_sync;
    logic             sec_prev;
    logic             deb_prev;
    logic             sec_tick;
    logic             deb_tick;
    logic [N_BTN-1:0] btn_s1;
    logic [N_BTN-1:0] btn_s2;

    // Ticks are registered so they land 3 clk after the raw level edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_sync <= 2'b00;
            deb_sync <= 2'b00;
            sec_prev <= 1'b0;
            deb_prev <= 1'b0;
            sec_tick <= 1'b0;
            deb_tick <= 1'b0;
            btn_s1   <= '0;
            btn_s2   <= '0;
        end else begin
            sec_sync <= {sec_sync[0], bus.sec_lvl};
            deb_sync <= {deb_sync[0], bus.deb_lvl};
            sec_prev <= sec_sync[1];
            deb_prev <= deb_sync[1];
            sec_tick <= sec_sync[1] & ~sec_prev;
            deb_tick <= deb_sync[1] & ~deb_prev;
            btn_s1   <= btn_raw;
            btn_s2   <= btn_s1;
        end
    end

    logic [N_BTN-1:0] deb_state;
    logic [N_BTN-1:0] deb_state_d;
    logic [N_BTN-1:0] press;

    generate
        for (genvar b = 0; b < N_BTN; b++) begin : g_deb
            logic             cand;
            logic [CNT_W-1:0] cnt;
            logic             state_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cand    <= 1'b0;
                    cnt     <= '0;
                    state_q <= 1'b0;
                end else if (deb_tick) begin
                    if (btn_s2[b] == cand) begin
                        if (cnt != CNT_W'(DEB_CNT))
                            cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(DEB_CNT - 1))
                            state_q <= cand;
                    end else begin
                        cand <= btn_s2[b];
                        cnt  <= CNT_W'(1);
                    end
                end
            end

            assign deb_state[b] = state_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            deb_state_d <= '0;
        else
            deb_state_d <= deb_state;
    end

    assign press = deb_state & ~deb_state_d;

    logic       start_p;
    logic       clr_p;
    logic [1:0] state;
    logic [1:0] state_nx;

    assign start_p = press[BTN_START];
    assign clr_p   = press[BTN_CLR];

    // Clear has priority over start when both land in the same cycle.
    always_comb begin
        state_nx = state;
        if (clr_p) begin
            state_nx = S_IDLE;
        end else if (start_p) begin
            case (state)
                S_IDLE:  state_nx = S_RUN;
                S_RUN:   state_nx = S_PAUSE;
                S_PAUSE: state_nx = S_RUN;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] m0;
    logic [3:0] m1;
    logic       run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_nx;
            run_q <= (state == S_RUN);
        end
    end

    // Counting follows the registered state, so a tick coincident with
    // RUN->PAUSE still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 4'd0;
            s1 <= 4'd0;
            m0 <= 4'd0;
            m1 <= 4'd0;
        end else if (clr_p) begin
            s0 <= 4'd0;
            s1 <= 4'd0;
            m0 <= 4'd0;
            m1 <= 4'd0;
        end else if (sec_tick && state == S_RUN) begin
            if (s0 != 4'd9) begin
                s0 <= s0 + 4'd1;
            end else begin
                s0 <= 4'd0;
                if (s1 != 4'd5) begin
                    s1 <= s1 + 4'd1;
                end else begin
                    s1 <= 4'd0;
                    if (m0 != 4'd9) begin
                        m0 <= m0 + 4'd1;
                    end else begin
                        m0 <= 4'd0;
                        m1 <= (m1 != 4'd5) ? m1 + 4'd1 : 4'd0;
                    end
                end
            end
        end
    end

    logic [15:0] live_time;
    logic [15:0] shown;

    assign live_time = {m1, m0, s1, s0};

`ifdef STOPWATCH_LAP_EN
    logic        freeze;
    logic [15:0] lap_time;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freeze   <= 1'b0;
            lap_time <= 16'h0000;
        end else if (clr_p || state_nx != S_RUN) begin
            freeze <= 1'b0;
        end else if (press[BTN_LAP]) begin
            freeze <= ~freeze;
            if (!freeze)
                lap_time <= live_time;
        end
    end

    assign shown = freeze ? lap_time : live_time;
`else
    assign shown = live_time;
`endif

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    logic [7:0] ssd_q;
    logic [3:0] ssd_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssd_q    <= 8'hFF;
            ssd_en_q <= 4'hF;
        end else begin
            case (bus.scan_sel)
                2'd0: begin
                    ssd_q    <= seg7(shown[3:0]);
                    ssd_en_q <= 4'b1110;
                end
                2'd1: begin
                    ssd_q    <= seg7(shown[7:4]);
                    ssd_en_q <= 4'b1101;
                end
                2'd2: begin
                    ssd_q    <= seg7(shown[11:8]) & 8'hFE;
                    ssd_en_q <= 4'b1011;
                end
                default: begin
                    ssd_q    <= seg7(shown[15:12]);
                    ssd_en_q <= 4'b0111;
                end
            endcase
        end
    end

    assign bus.ssd     = ssd_q;
    assign bus.ssd_en  = ssd_en_q;
    assign bus.running = run_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ==================================================================
// tb_stopwatch_ctrl - directed self-checking bench for stopwatch_ctrl;
// lap steps run when STOPWATCH_LAP_EN is defined.  Rev 1.0
// ==================================================================
module tb_stopwatch_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(.DEB_CNT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sw.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seg(input int d);
        logic [7:0] s;
        case (d)
            0: s = 8'h03;  1: s = 8'h9F;  2: s = 8'h25;  3: s = 8'h0D;
            4: s = 8'h99;  5: s = 8'h49;  6: s = 8'h41;  7: s = 8'h1F;
            8: s = 8'h01;  9: s = 8'h09;  default: s = 8'hFF;
        endcase
        return s;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_run(input string tag, input logic exp);
        chk(tag, {7'd0, sw.running}, {7'd0, exp});
    endtask

    task automatic chk_disp(input string tag, input int m1, input int m0, input int s1, input int s0);
        int         digs[4];
        logic [3:0] en_exp[4];
        logic [7:0] s_exp;
        digs[0] = s0; digs[1] = s1; digs[2] = m0; digs[3] = m1;
        en_exp[0] = 4'b1110; en_exp[1] = 4'b1101; en_exp[2] = 4'b1011; en_exp[3] = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk) sw.scan_sel = 2'(i);
            @(negedge clk);
            s_exp = seg(digs[i]);
            if (i == 2) s_exp = s_exp & 8'hFE;
            chk($sformatf("%s_seg%0d", tag, i), sw.ssd, s_exp);
            chk($sformatf("%s_en%0d", tag, i), {4'd0, sw.ssd_en}, {4'd0, en_exp[i]});
        end
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: sw.btn_start = v;
            1: sw.btn_clr   = v;
`ifdef STOPWATCH_LAP_EN
            2: sw.btn_lap   = v;
`endif
            default: ;
        endcase
    endtask

    // One debounce strobe; optionally a second strobe rising one clk later
    // so its tick coincides with the press pulse of this strobe.
    task automatic deb_strobe(input bit with_sec);
        @(negedge clk) sw.deb_lvl = 1'b1;
        @(negedge clk) if (with_sec) sw.sec_lvl = 1'b1;
        @(negedge clk) sw.deb_lvl = 1'b0;
        @(negedge clk) sw.sec_lvl = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic sec_strobes(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk) sw.sec_lvl = 1'b1;
            @(negedge clk);
            @(negedge clk) sw.sec_lvl = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic press_release(input int b);
        @(negedge clk) set_btn(b, 1'b1);
        repeat (3) deb_strobe(1'b0);
        @(negedge clk) set_btn(b, 1'b0);
        repeat (3) deb_strobe(1'b0);
    endtask

    initial begin
        rst_n        = 1'b1;
        sw.sec_lvl   = 1'b0;
        sw.deb_lvl   = 1'b0;
        sw.scan_sel  = 2'd0;
        sw.btn_start = 1'b0;
        sw.btn_clr   = 1'b0;
`ifdef STOPWATCH_LAP_EN
        sw.btn_lap   = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ssd", sw.ssd, 8'hFF);
        chk("rst_en", {4'd0, sw.ssd_en}, 8'h0F);
        chk_run("rst_run", 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk_disp("init", 0, 0, 0, 0);
        chk_run("init_run", 1'b0);

        // Bouncing start, then held: a single press only.
        @(negedge clk) sw.btn_start = 1'b1;
        deb_strobe(1'b0);
        @(negedge clk) sw.btn_start = 1'b0;
        deb_strobe(1'b0);
        @(negedge clk) sw.btn_start = 1'b1;
        deb_strobe(1'b0);
        deb_strobe(1'b0);
        chk_run("bounce_early", 1'b0);
        deb_strobe(1'b0);
        chk_run("bounce_run", 1'b1);
        deb_strobe(1'b0);
        chk_run("bounce_hold", 1'b1);
        @(negedge clk) sw.btn_start = 1'b0;
        repeat (3) deb_strobe(1'b0);
        chk_run("release_nop", 1'b1);

        sec_strobes(599);
        chk_disp("t0959", 0, 9, 5, 9);
        sec_strobes(1);
        chk_disp("t1000", 1, 0, 0, 0);
        sec_strobes(2999);
        chk_disp("t5959", 5, 9, 5, 9);
        sec_strobes(1);
        chk_disp("wrap", 0, 0, 0, 0);
        chk_run("wrap_run", 1'b1);

        sec_strobes(3);
        press_release(0);
        chk_run("pause_run", 1'b0);
        sec_strobes(5);
        chk_disp("paused", 0, 0, 0, 3);
        press_release(0);
        chk_run("resume_run", 1'b1);
        sec_strobes(2);
        chk_disp("resumed", 0, 0, 0, 5);

        // clr and start debounced together, tick coincident.
        @(negedge clk) begin sw.btn_start = 1'b1; sw.btn_clr = 1'b1; end
        deb_strobe(1'b0);
        deb_strobe(1'b0);
        deb_strobe(1'b1);
        chk_run("clrwin_run", 1'b0);
        chk_disp("clrwin", 0, 0, 0, 0);
        @(negedge clk) begin sw.btn_start = 1'b0; sw.btn_clr = 1'b0; end
        repeat (3) deb_strobe(1'b0);
        sec_strobes(2);
        chk_disp("idle_hold", 0, 0, 0, 0);

        // Reset mid-run with start held across reset.
        press_release(0);
        sec_strobes(3);
        chk_disp("prerst", 0, 0, 0, 3);
        @(negedge clk) sw.btn_start = 1'b1;
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mrst_ssd", sw.ssd, 8'hFF);
        chk("mrst_en", {4'd0, sw.ssd_en}, 8'h0F);
        chk_run("mrst_run", 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_disp("postrst", 0, 0, 0, 0);
        deb_strobe(1'b0);
        deb_strobe(1'b0);
        chk_run("postrst_early", 1'b0);
        deb_strobe(1'b0);
        chk_run("postrst_run", 1'b1);
        @(negedge clk) sw.btn_start = 1'b0;
        repeat (3) deb_strobe(1'b0);

        // Pause coincident with a tick: the tick still counts.
        @(negedge clk) sw.btn_start = 1'b1;
        deb_strobe(1'b0);
        deb_strobe(1'b0);
        deb_strobe(1'b1);
        chk_run("pause_tick_run", 1'b0);
        chk_disp("pause_tick", 0, 0, 0, 1);
        @(negedge clk) sw.btn_start = 1'b0;
        repeat (3) deb_strobe(1'b0);

`ifdef STOPWATCH_LAP_EN
        press_release(1);
        press_release(0);
        sec_strobes(10);
        chk_disp("lap_pre", 0, 0, 1, 0);
        press_release(2);
        sec_strobes(4);
        chk_disp("lap_frozen", 0, 0, 1, 0);
        press_release(2);
        chk_disp("lap_live", 0, 0, 1, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
